// File: rtl/poly_oscillator_pkg.sv
// Shared oscillator constants and types: key/sample types, datapath widths,
// sample rate, waveform mode encodings and the scan FSM states.
package poly_oscillator_pkg;

  localparam int OSC_WIDTH = 24;
  localparam int OSC_DEPTH = 12;
  localparam int FS_HZ     = 48000;
  localparam int KEY_COUNT = 128;

  typedef logic [6:0]                  key_t;
  typedef logic signed [OSC_DEPTH-1:0] volt_t;

  typedef enum logic [1:0] {
    MODE_SAW      = 2'b00,
    MODE_SQUARE   = 2'b01,
    MODE_TRIANGLE = 2'b10,
    MODE_PULSE    = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_OUT
  } state_e;

  // Index width that stays legal for a single-voice build.
  function automatic int index_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/poly_oscillator_key_inc_rom.sv
// Key number to phase increment table, elaborated from PHASE_W and the sample
// rate (key 49 = 440 Hz, 12 keys per octave); key 0 maps to a zero increment.
module poly_oscillator_key_inc_rom
  import poly_oscillator_pkg::*;
#(
  parameter int PHASE_W = OSC_WIDTH,
  parameter int FS      = FS_HZ
) (
  input  key_t               key,
  output logic [PHASE_W-1:0] inc
);

  logic [PHASE_W-1:0] inc_table [KEY_COUNT];

  assign inc_table[0] = '0;

  for (genvar gi = 1; gi < KEY_COUNT; gi++) begin : g_entry
    localparam real FREQ_HZ  = 440.0 * (2.0 ** ((gi - 49) / 12.0));
    localparam real INC_REAL = FREQ_HZ * (2.0 ** PHASE_W) / FS;
    assign inc_table[gi] = PHASE_W'($rtoi(INC_REAL + 0.5));
  end

  assign inc = inc_table[key];

endmodule

// File: rtl/poly_oscillator.sv
// N-voice time-multiplexed oscillator: one shared phase/waveform datapath
// visits each voice per sample tick and emits the signed sum of all voices.
module poly_oscillator
  import poly_oscillator_pkg::*;
#(
  parameter int N_VOICES = 4,
  parameter int PHASE_W  = OSC_WIDTH,
  parameter int DEPTH    = OSC_DEPTH
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         sample_tick,
  input  logic                                         cfg_valid,
  output logic                                         cfg_ready,
  input  logic [index_bits(N_VOICES)-1:0]              cfg_voice,
  input  key_t                                         cfg_key,
  input  logic                                         cfg_gate,
  input  logic [1:0]                                   cfg_mode,
  output logic signed [DEPTH+$clog2(N_VOICES)-1:0]     mix,
  output logic                                         mix_valid,
  output logic                                         overrun
);

  localparam int VOICE_W = index_bits(N_VOICES);
  localparam int MIX_W   = DEPTH + $clog2(N_VOICES);
  localparam logic [DEPTH-1:0] POS_FULL = {1'b0, {(DEPTH-1){1'b1}}};
  localparam logic [DEPTH-1:0] NEG_FULL = {1'b1, {(DEPTH-1){1'b0}}};

  state_e                    state_reg;
  logic [VOICE_W-1:0]        idx_reg;
  logic signed [MIX_W-1:0]   acc_reg;
  logic signed [MIX_W-1:0]   mix_reg;
  logic                      mix_valid_reg;
  logic                      overrun_reg;
  logic                      cfg_ready_reg;

  key_t               key_arr   [N_VOICES];
  logic               gate_arr  [N_VOICES];
  mode_e              mode_arr  [N_VOICES];
  logic [PHASE_W-1:0] phase_arr [N_VOICES];

  logic                     cfg_fire;
  key_t                     cur_key;
  logic [PHASE_W-1:0]       cur_inc;
  logic                     voice_on;
  logic [PHASE_W-1:0]       phase_sum;
  logic [DEPTH-1:0]         p;
  logic [DEPTH-1:0]         tri_fold;
  logic [DEPTH-1:0]         wave;
  logic signed [DEPTH-1:0]  voice_value;

  assign cfg_fire  = cfg_valid && cfg_ready_reg;
  assign cur_key   = key_arr[idx_reg];
  assign voice_on  = gate_arr[idx_reg] && (cur_key != '0);
  assign phase_sum = phase_arr[idx_reg] + cur_inc;
  assign p         = phase_sum[PHASE_W-1 -: DEPTH];
  assign tri_fold  = p[DEPTH-1] ? ~p : p;

  poly_oscillator_key_inc_rom #(
    .PHASE_W (PHASE_W),
    .FS      (FS_HZ)
  ) u_rom (
    .key (cur_key),
    .inc (cur_inc)
  );

  // Subtracting H from an unsigned DEPTH-bit code is just an MSB flip.
  always_comb begin
    wave = '0;
    case (mode_arr[idx_reg])
      MODE_SAW:      wave = {~p[DEPTH-1], p[DEPTH-2:0]};
      MODE_SQUARE:   wave = p[DEPTH-1] ? POS_FULL : NEG_FULL;
      MODE_TRIANGLE: wave = {~tri_fold[DEPTH-2], tri_fold[DEPTH-3:0], 1'b0};
      MODE_PULSE:    wave = (p[DEPTH-1:DEPTH-2] == 2'b00) ? POS_FULL : NEG_FULL;
      default:       wave = '0;
    endcase
    voice_value = voice_on ? wave : '0;
  end

  for (genvar gi = 0; gi < N_VOICES; gi++) begin : g_voice
    key_t               key_reg;
    logic               gate_reg;
    mode_e              mode_reg;
    logic [PHASE_W-1:0] phase_reg;
    logic               cfg_hit;
    logic               scan_hit;

    assign cfg_hit  = cfg_fire && (cfg_voice == VOICE_W'(gi));
    assign scan_hit = (state_reg == ST_SCAN) && (idx_reg == VOICE_W'(gi)) && voice_on;

    always_ff @(posedge clk) begin
      if (rst) begin
        key_reg   <= '0;
        gate_reg  <= 1'b0;
        mode_reg  <= MODE_SAW;
        phase_reg <= '0;
      end else if (cfg_hit) begin
        key_reg  <= cfg_key;
        gate_reg <= cfg_gate;
        mode_reg <= mode_e'(cfg_mode);
        // Note-on restarts the waveform; a legato pitch change keeps phase.
        if (cfg_gate && !gate_reg) phase_reg <= '0;
      end else if (scan_hit) begin
        phase_reg <= phase_sum;
      end
    end

    assign key_arr[gi]   = key_reg;
    assign gate_arr[gi]  = gate_reg;
    assign mode_arr[gi]  = mode_reg;
    assign phase_arr[gi] = phase_reg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      idx_reg       <= '0;
      acc_reg       <= '0;
      mix_reg       <= '0;
      mix_valid_reg <= 1'b0;
      overrun_reg   <= 1'b0;
      cfg_ready_reg <= 1'b1;
    end else begin
      mix_valid_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (sample_tick) begin
            state_reg     <= ST_SCAN;
            idx_reg       <= '0;
            acc_reg       <= '0;
            cfg_ready_reg <= 1'b0;
          end
        end
        ST_SCAN: begin
          acc_reg <= acc_reg + MIX_W'(voice_value);
          if (idx_reg == VOICE_W'(N_VOICES - 1)) state_reg <= ST_OUT;
          else                                   idx_reg   <= idx_reg + VOICE_W'(1);
          if (sample_tick) overrun_reg <= 1'b1;
        end
        ST_OUT: begin
          mix_reg       <= acc_reg;
          mix_valid_reg <= 1'b1;
          cfg_ready_reg <= 1'b1;
          state_reg     <= ST_IDLE;
          if (sample_tick) overrun_reg <= 1'b1;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign mix       = mix_reg;
  assign mix_valid = mix_valid_reg;
  assign overrun   = overrun_reg;
  assign cfg_ready = cfg_ready_reg;

endmodule

// File: doc/poly_oscillator.md
# poly_oscillator

Time-multiplexed, parametrised successor to the single-voice oscillator: N voices share one phase-accumulator/waveform datapath, each voice with its own key, gate and waveform mode, and the block emits one summed signed sample per sample tick. It sits between the key/voice-allocation logic (configuration side) and the output DAC/filter chain (sample side). Key-to-frequency mapping keeps the existing convention: key 49 = 440 Hz, 12 keys per octave.

## Interface
- N_VOICES, 4: voice count, power of two, 1–16
- PHASE_W, 24: phase accumulator width (`OSC_WIDTH`)
- DEPTH, 12: per-voice sample width (`OSC_DEPTH`)
- clk  in  1  system clock (100 MHz)
- rst  in  1  reset; one clock; synchronous, active-high
- sample_tick  in  1  one-cycle strobe starting a sample computation
- cfg_valid  in  1  configuration write request
- cfg_ready  out  1  configuration write accepted when high with cfg_valid
- cfg_voice  in  clog2(N_VOICES)  target voice
- cfg_key  in  7 (`key_t`)  key number; 0 = voice off
- cfg_gate  in  1  note gate
- cfg_mode  in  2  00 saw, 01 square, 10 triangle, 11 pulse 25 %
- mix  out  DEPTH+clog2(N_VOICES)  signed sum of all voices
- mix_valid  out  1  one-cycle strobe, mix updated
- overrun  out  1  sticky: tick arrived while busy

## Operation
- Per-voice state registers: key, gate, mode, phase[PHASE_W].
- FSM states: IDLE, SCAN, OUT. IDLE → SCAN on sample_tick; SCAN visits voices 0..N_VOICES-1, one per cycle; SCAN → OUT after last voice; OUT → IDLE unconditionally.
- Per visited voice: if gate=1 and key≠0, phase ← phase + inc(key) (mod 2^PHASE_W) and value from the updated phase; else phase unchanged, value 0.
- Waveform from p = top DEPTH bits of the updated phase, H = 2^(DEPTH-1): saw = p − H; square = MSB ? H−1 : −H; triangle = (MSB ? ~p : p) shifted left 1, then − H; pulse = top two bits = 00 ? H−1 : −H.
- Accumulator sign-extends each value and sums; mix register loaded in OUT. No saturation: width is sufficient by construction.
- inc(key) = round(440·2^((key−49)/12)·2^PHASE_W / Fs), Fs = 48 kHz; keys 1–127 valid.
- Config write: on cfg_valid & cfg_ready, the voice's key/gate/mode are updated. A gate 0→1 transition clears that voice's phase to 0. A write with gate already 1 changes pitch without a phase reset.
- cfg_ready = 1 only in IDLE; writes never collide with the scan.
- sample_tick in SCAN or OUT is dropped and sets overrun; cleared only by rst.

## Timing
- Reset values: mix 0, mix_valid 0, cfg_ready 1, overrun 0, all phases/keys/gates/modes 0, FSM IDLE.
- Latency: mix_valid asserts N_VOICES+2 cycles after the sample_tick cycle; minimum tick spacing N_VOICES+2 cycles.
- Increment ROM is combinational (registered variant allowed only if the SCAN state adds a pipeline stage and latency is re-documented).
- rst mid-scan: the scan aborts, no mix_valid, state returns to reset values next cycle.
- sample_tick and cfg_valid in the same IDLE cycle: config write takes effect, the scan uses the new values from the next cycle.

## Structure
- Shared constants file: `key_t`, `volt_t`, `OSC_WIDTH`, `OSC_DEPTH`, Fs, mode encodings.
- One sub-module: key_inc_rom (128-entry key → increment table, generated for PHASE_W/Fs; entry 0 = 0).

## Test plan
- Reset: hold rst 3 cycles → mix=0, mix_valid=0, cfg_ready=1, overrun=0.
- Voice 0 key 49 saw gate 1, others off, one tick → inc=153791, phase=153791, mix = 37−2048 = −2011, mix_valid exactly N_VOICES+2 cycles after the tick.
- Key 49 run for 48000 ticks → phase wraps 440 times ±1; sweep keys 25–79 → measured period within 0.1 % of 440·2^((k−49)/12).
- All 4 voices square, phase MSB 0 → mix = −8192; gate 0→1 write → that voice's phase reads 0 before the next tick.
- Second tick 2 cycles after the first → overrun=1, only one mix_valid; cfg_valid during SCAN → cfg_ready=0, write lands in IDLE.
- rst asserted mid-SCAN → no mix_valid, all registers at reset values next cycle.
